k2_fetch_unit: RTL and testbench

- Instruction fetch/sequencer for the K2 processor; drives the 4-bit address into the instruction memory and captures the returned 8-bit instruction.
- Holds the program counter (PC) and instruction register (IR), and resolves jumps using flags from the datapath.
- Hands each instruction to decode/datapath with a valid strobe.

---
 rtl/k2_fetch_unit.sv | 120 ++++++++++++
 tb/tb_k2_fetch_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k2_fetch_unit.sv
// K2 instruction fetch/sequencer: PC, IR and jump resolution over a FETCH/EXECUTE cycle.
// Optional breakpoint support is compiled in with `define K2_FETCH_BREAKPOINT_EN.
module k2_fetch_unit #(
   parameter int ADDR_W    = 4,
   parameter int INST_W    = 8,
   parameter int LAST_ADDR = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              c_flag,
   input  logic              z_flag,
   input  logic [INST_W-1:0] inst,
`ifdef K2_FETCH_BREAKPOINT_EN
   input  logic [ADDR_W-1:0] bp_addr,
   input  logic              bp_en,
   input  logic              resume,
   output logic              bp_hit,
`endif
   output logic [ADDR_W-1:0] s,
   output logic [INST_W-1:0] ir,
   output logic              ir_valid,
   output logic              jump_taken,
   output logic              halted
);

   localparam logic [1:0] ST_FETCH   = 2'd0;
   localparam logic [1:0] ST_EXECUTE = 2'd1;
   localparam logic [1:0] ST_HALT    = 2'd2;
`ifdef K2_FETCH_BREAKPOINT_EN
   localparam logic [1:0] ST_BREAK   = 2'd3;
`endif

   localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc;
   logic              cond_ok;
   logic              take;
`ifdef K2_FETCH_BREAKPOINT_EN
   logic              bypass;
`endif

   // Jump encoding: ir[7] marks a jump, ir[5:4] picks the condition, low bits are the target.
   always_comb begin
      cond_ok = 1'b0;
      case (ir[5:4])
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = c_flag;
         2'b10:   cond_ok = z_flag;
         default: cond_ok = ~c_flag;
      endcase
      take = ir[INST_W-1] & cond_ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_FETCH;
         pc         <= '0;
         ir         <= '0;
         jump_taken <= 1'b0;
`ifdef K2_FETCH_BREAKPOINT_EN
         bypass     <= 1'b0;
`endif
      end else if (stall) begin
         jump_taken <= 1'b0;
      end else begin
         jump_taken <= 1'b0;
         case (state)
            ST_FETCH: begin
`ifdef K2_FETCH_BREAKPOINT_EN
               // bypass lets the resumed address fetch once without re-triggering
               if (bp_en && (pc == bp_addr) && !bypass) begin
                  state <= ST_BREAK;
               end else begin
                  ir     <= inst;
                  state  <= ST_EXECUTE;
                  bypass <= 1'b0;
               end
`else
               ir    <= inst;
               state <= ST_EXECUTE;
`endif
            end
            ST_EXECUTE: begin
               if (take) begin
                  pc         <= ir[ADDR_W-1:0];
                  jump_taken <= 1'b1;
                  state      <= ST_FETCH;
               end else if (pc == LAST_PC) begin
                  state <= ST_HALT;
               end else begin
                  pc    <= pc + 1'b1;
                  state <= ST_FETCH;
               end
            end
            ST_HALT: begin
               state <= ST_HALT;
            end
`ifdef K2_FETCH_BREAKPOINT_EN
            ST_BREAK: begin
               if (resume) begin
                  state  <= ST_FETCH;
                  bypass <= 1'b1;
               end
            end
`endif
            default: state <= ST_FETCH;
         endcase
      end
   end

   assign s        = pc;
   assign ir_valid = (state == ST_EXECUTE);
   assign halted   = (state == ST_HALT);
`ifdef K2_FETCH_BREAKPOINT_EN
   assign bp_hit   = (state == ST_BREAK);
`endif

endmodule

// File: tb/tb_k2_fetch_unit.sv
// Bench for k2_fetch_unit: three instances (LAST_ADDR 8, 15, 14) share one program memory
// and are checked each cycle against an instruction-level model plus directed literal checks.
module tb_k2_fetch_unit;
   localparam int N = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       stall = 1'b0;
   logic       c_flag = 1'b0;
   logic       z_flag = 1'b0;
   logic [7:0] mem [16];
   logic [3:0] s_a [N];
   logic [7:0] ir_a [N];
   logic [7:0] inst_a [N];
   logic       v_a [N];
   logic       jt_a [N];
   logic       h_a [N];
`ifdef K2_FETCH_BREAKPOINT_EN
   logic [3:0] bp_addr = 4'd0;
   logic       bp_en = 1'b0;
   logic       resume = 1'b0;
   logic       bh_a [N];
`endif

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      assign inst_a[g] = mem[s_a[g]];
      k2_fetch_unit #(
         .ADDR_W(4), .INST_W(8), .LAST_ADDR(g == 0 ? 8 : (g == 1 ? 15 : 14))
      ) u_dut (
         .clk(clk), .reset(reset), .stall(stall), .c_flag(c_flag), .z_flag(z_flag),
         .inst(inst_a[g]),
`ifdef K2_FETCH_BREAKPOINT_EN
         .bp_addr(bp_addr), .bp_en(bp_en), .resume(resume), .bp_hit(bh_a[g]),
`endif
         .s(s_a[g]), .ir(ir_a[g]), .ir_valid(v_a[g]), .jump_taken(jt_a[g]), .halted(h_a[g])
      );
   end

   // Instruction-level model: each instruction is fetched, then executed.
   int         m_pc [N];
   logic [7:0] m_ir [N];
   bit         m_exec [N];
   bit         m_halt [N];
   bit         m_jt [N];
`ifdef K2_FETCH_BREAKPOINT_EN
   bit         m_brk [N];
   bit         m_byp [N];
`endif

   function automatic int last_of(int i);
      return (i == 0) ? 8 : ((i == 1) ? 15 : 14);
   endfunction

   function automatic bit jump_ok(logic [7:0] op, logic c, logic z);
      logic [1:0] cc;
      cc = op[5:4];
      if (!op[7]) return 1'b0;
      if (cc == 2'd0) return 1'b1;
      if (cc == 2'd1) return c;
      if (cc == 2'd2) return z;
      return !c;
   endfunction

   always @(posedge clk or posedge reset) begin
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            m_pc[i] = 0; m_ir[i] = 8'h00; m_exec[i] = 0; m_halt[i] = 0; m_jt[i] = 0;
`ifdef K2_FETCH_BREAKPOINT_EN
            m_brk[i] = 0; m_byp[i] = 0;
`endif
         end else begin
            m_jt[i] = 0;
            if (!m_halt[i] && !stall) begin
               if (m_exec[i]) begin
                  m_exec[i] = 0;
                  if (jump_ok(m_ir[i], c_flag, z_flag)) begin
                     m_pc[i] = int'(m_ir[i][3:0]);
                     m_jt[i] = 1;
                  end else if (m_pc[i] == last_of(i)) begin
                     m_halt[i] = 1;
                  end else begin
                     m_pc[i] = (m_pc[i] + 1) % 16;
                  end
               end else begin
`ifdef K2_FETCH_BREAKPOINT_EN
                  if (m_brk[i]) begin
                     if (resume) begin m_brk[i] = 0; m_byp[i] = 1; end
                  end else if (bp_en && m_pc[i] == int'(bp_addr) && !m_byp[i]) begin
                     m_brk[i] = 1;
                  end else begin
                     m_ir[i] = mem[m_pc[i]]; m_exec[i] = 1; m_byp[i] = 0;
                  end
`else
                  m_ir[i] = mem[m_pc[i]];
                  m_exec[i] = 1;
`endif
               end
            end
         end
      end
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         for (int i = 0; i < N; i++) begin
            chk($sformatf("model_s[%0d]", i), 32'(s_a[i]), 32'(m_pc[i]));
            chk($sformatf("model_ir[%0d]", i), 32'(ir_a[i]), 32'(m_ir[i]));
            chk($sformatf("model_valid[%0d]", i), 32'(v_a[i]), 32'(m_exec[i] && !m_halt[i]));
            chk($sformatf("model_jt[%0d]", i), 32'(jt_a[i]), 32'(m_jt[i]));
            chk($sformatf("model_halt[%0d]", i), 32'(h_a[i]), 32'(m_halt[i]));
`ifdef K2_FETCH_BREAKPOINT_EN
            chk($sformatf("model_bp[%0d]", i), 32'(bh_a[i]), 32'(m_brk[i]));
`endif
         end
      end
   end

   task automatic cyc(int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 16; a++) mem[a] = 8'h00;
   endtask

   task automatic restart();
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
   endtask

   initial begin
      stall = 1'b0;
      clear_mem();
      reset = 1'b1;
      cyc(2);
      cmp_en = 1'b1;

      // Sequential fetch, stall, then fall-through halts at each LAST_ADDR
      clear_mem(); mem[0] = 8'h08; mem[1] = 8'h19; mem[2] = 8'h20;
      restart();
      chk("reset_s", 32'(s_a[0]), 32'd0);
      chk("reset_ir", 32'(ir_a[0]), 32'h00);
      chk("reset_valid", 32'(v_a[0]), 32'd0);
      chk("reset_halt", 32'(h_a[0]), 32'd0);
      cyc(1);
      chk("seq_ir0", 32'(ir_a[0]), 32'h08);
      chk("seq_valid1", 32'(v_a[0]), 32'd1);
      chk("seq_s0", 32'(s_a[0]), 32'd0);
      cyc(1);
      chk("seq_s1", 32'(s_a[0]), 32'd1);
      chk("seq_valid0", 32'(v_a[0]), 32'd0);
      cyc(1);
      chk("seq_ir1", 32'(ir_a[0]), 32'h19);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         chk("stall_ir", 32'(ir_a[0]), 32'h19);
         chk("stall_valid", 32'(v_a[0]), 32'd1);
         chk("stall_s", 32'(s_a[0]), 32'd1);
      end
      stall = 1'b0;
      cyc(1);
      chk("post_stall_s", 32'(s_a[0]), 32'd2);
      cyc(1);
      chk("seq_ir2", 32'(ir_a[0]), 32'h20);
      cyc(20);
      stall = 1'b1;
      cyc(3);
      stall = 1'b0;
      cyc(20);
      chk("halt8_h", 32'(h_a[0]), 32'd1);
      chk("halt8_s", 32'(s_a[0]), 32'd8);
      chk("halt15_s", 32'(s_a[1]), 32'd15);
      chk("halt14_s", 32'(s_a[2]), 32'd14);
      chk("halt14_h", 32'(h_a[2]), 32'd1);

      // Conditional jump on carry: taken then not taken
      clear_mem(); mem[0] = 8'h92;
      c_flag = 1'b1;
      restart();
      cyc(2);
      chk("jc_taken_s", 32'(s_a[0]), 32'd2);
      chk("jc_taken_jt", 32'(jt_a[0]), 32'd1);
      cyc(1);
      chk("jc_pulse_end", 32'(jt_a[0]), 32'd0);
      c_flag = 1'b0;
      restart();
      cyc(2);
      chk("jc_not_s", 32'(s_a[0]), 32'd1);
      chk("jc_not_jt", 32'(jt_a[0]), 32'd0);

      // Zero and not-carry conditions
      clear_mem(); mem[0] = 8'hA5; mem[5] = 8'hB7; mem[7] = 8'h93;
      z_flag = 1'b1; c_flag = 1'b0;
      restart();
      cyc(2);
      chk("jz_s", 32'(s_a[0]), 32'd5);
      cyc(2);
      chk("jnc_s", 32'(s_a[0]), 32'd7);
      chk("jnc_jt", 32'(jt_a[0]), 32'd1);
      cyc(2);
      chk("jc_fall_s", 32'(s_a[0]), 32'd8);
      cyc(2);
      chk("jz_halt", 32'(h_a[0]), 32'd1);
      z_flag = 1'b0;

      // Jump from LAST_ADDR beats the halt
      clear_mem(); mem[8] = 8'h80;
      restart();
      cyc(18);
      chk("jlast_s", 32'(s_a[0]), 32'd0);
      chk("jlast_jt", 32'(jt_a[0]), 32'd1);
      cyc(30);
      chk("jlast_nohalt", 32'(h_a[0]), 32'd0);

      // Wrap past 15 versus halt at 15
      clear_mem(); mem[0] = 8'h8F;
      restart();
      cyc(4);
      chk("wrap_s8", 32'(s_a[0]), 32'd0);
      chk("halt15_h", 32'(h_a[1]), 32'd1);
      chk("wrap_s14", 32'(s_a[2]), 32'd0);
      chk("wrap_h14", 32'(h_a[2]), 32'd0);
      cyc(20);
      chk("halt15_hold", 32'(s_a[1]), 32'd15);

      // Asynchronous reset during EXECUTE of a taken jump
      clear_mem(); mem[0] = 8'h92;
      c_flag = 1'b1;
      restart();
      cyc(1);
      chk("pre_rst_ir", 32'(ir_a[0]), 32'h92);
      #2 reset = 1'b1;
      #1;
      chk("async_s", 32'(s_a[0]), 32'd0);
      chk("async_ir", 32'(ir_a[0]), 32'h00);
      chk("async_valid", 32'(v_a[0]), 32'd0);
      cyc(1);
      reset = 1'b0;
      cyc(2);
      chk("after_rst_s", 32'(s_a[0]), 32'd2);
      c_flag = 1'b0;

`ifdef K2_FETCH_BREAKPOINT_EN
      // Breakpoint at address 3, then resume
      clear_mem(); mem[2] = 8'h2C; mem[3] = 8'h33;
      bp_addr = 4'd3; bp_en = 1'b1;
      restart();
      cyc(7);
      chk("bp_hit", 32'(bh_a[0]), 32'd1);
      chk("bp_ir", 32'(ir_a[0]), 32'h2C);
      chk("bp_s", 32'(s_a[0]), 32'd3);
      cyc(3);
      chk("bp_hold", 32'(bh_a[0]), 32'd1);
      resume = 1'b1;
      cyc(1);
      resume = 1'b0;
      chk("bp_resumed", 32'(bh_a[0]), 32'd0);
      cyc(1);
      chk("bp_ir3", 32'(ir_a[0]), 32'h33);
      cyc(1);
      chk("bp_s4", 32'(s_a[0]), 32'd4);
      bp_en = 1'b0;
`endif

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
